hamming_enc_stream: RTL and testbench
=====================================

Name: hamming_enc_stream

Overview:
- Streaming Hamming(IP_BIT+4, IP_BIT) single-error-correcting encoder. It is the transmit-side counterpart of the team's combinational Hamming decoder IP.
- Accepts one data word per valid/ready handshake and computes the parity iteratively, one data bit per cycle.
- Presents a registered codeword on a valid/ready output port, in exactly the bit layout the decoder consumes.
- Sits between a data producer and a channel or storage element that is protected by the decoder.

Parameters:
- IP_BIT, default 8. Data width. Legal range 5..11. Codeword width is IP_BIT+4.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: producer has a word on in_data.
- in_ready, output, 1: encoder can accept a word.
- in_data, input, IP_BIT: data word to encode.
- out_valid, output, 1: out_code holds a finished codeword.
- out_ready, input, 1: consumer takes out_code.
- out_code, output, IP_BIT+4: encoded codeword.
- enc_cnt, output, 8: count of codewords delivered, modulo 256.

Behaviour:
- Reset and clocking: one clock (clk); reset (rst) is synchronous and active-high. While rst=1 at a rising edge:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, out_code=0, enc_cnt=0;
  - internal data latch, bit counter and syndrome accumulator are cleared.
- Reset mid-operation: any word in CALC or HOLD is discarded, with no partial output.
- Codeword layout:
  - Position p (1..IP_BIT+4) maps to out_code[IP_BIT+4-p], so position 1 is the MSB.
  - Parity bits occupy positions 1, 2, 4 and 8.
  - in_data[IP_BIT-1] goes to position 3.
  - in_data[IP_BIT-2:IP_BIT-4] go to positions 5, 6, 7.
  - in_data[IP_BIT-5:0] go to positions 9..IP_BIT+4, MSB first.
- Parity rule: even parity. Parity bit at position 2^k equals bit k of the XOR of the position indices of all data bits that are 1. The XOR of the positions of all 1-bits in a valid codeword is therefore 0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_data, clear bit counter and 4-bit syndrome accumulator, go to CALC.
- State CALC:
  - in_ready=0.
  - Each cycle processes one latched data bit, index IP_BIT-1 down to 0. If the bit is 1, the accumulator XORs in that bit's position.
  - After IP_BIT cycles, load out_code from the data latch plus the final accumulator, and go to HOLD.
- State HOLD:
  - out_valid=1, in_ready=0.
  - out_code is held stable while out_valid=1 and out_ready=0.
  - On out_ready=1: enc_cnt increments (255 wraps to 0) and state returns to IDLE.
  - out_valid drops on the next cycle. There is no accept in the same cycle as output release.
- Latency: out_valid rises exactly IP_BIT rising edges after the accepting edge.
- Throughput: one word per IP_BIT+2 cycles when out_ready is held at 1.
- Handshake rules:
  - in_valid while in_ready=0 is ignored, and in_data is not sampled.
  - out_ready while out_valid=0 has no effect.
- Width rules:
  - The accumulator is 4 bits wide; position constants are 4-bit unsigned.
  - Unused codeword positions above IP_BIT+4 do not exist. No padding.

Optional Feature:
- Macro: HAMMING_ENC_ERR_INJECT_EN.
- When defined, an extra port is added: err_pos, input, 4 bits.
  - err_pos is sampled together with in_data on the accepting edge.
  - If 1 <= err_pos <= IP_BIT+4, the bit at position err_pos of the final out_code is inverted. This is a deliberate single-bit error, used to exercise the decoder.
  - err_pos=0, or a value above IP_BIT+4, produces an uncorrupted codeword.
- When undefined, the err_pos port and its logic are absent, and out_code is always the clean codeword.

Test Plan:
1. Reset handling, IP_BIT=8: hold rst=1 for 2 cycles, then release. Required: in_ready=1, out_valid=0, out_code=12'h000, enc_cnt=0. Then send in_data=8'h00. Required: out_code=12'h000, out_valid 8 edges after accept.
2. Encode 8'hA5. Required: out_code=12'hE45. Encode 8'hFF. Required: out_code=12'hEEF. Feeding each codeword to the decoder must return the original data.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: out_code stable at 12'hE45, in_ready=0, and a second in_valid pulse is ignored. Then raise out_ready. Required: enc_cnt increments by 1.
4. Wrap: deliver 256 words. Required: enc_cnt reads 0 after the 256th handshake.
5. Reset mid-CALC: assert rst 3 cycles after accepting 8'hA5. Required: out_valid never rises for that word, and enc_cnt stays 0.
6. With HAMMING_ENC_ERR_INJECT_EN defined: in_data=8'hA5, err_pos=5. Required: out_code=12'hEC5, and the decoder output equals 8'hA5. With err_pos=13, required: out_code=12'hE45.

Source files
------------

// File: rtl/hamming_enc_stream_if.sv
// Valid/ready bundle for the streaming Hamming encoder: word-in port,
// codeword-out port and the delivered-codeword counter.
// Optional macro HAMMING_ENC_ERR_INJECT_EN adds the err_pos input.
interface hamming_enc_stream_if #(
  parameter int unsigned IP_BIT = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [IP_BIT-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [IP_BIT+3:0] out_code;
  logic [7:0]        enc_cnt;
`ifdef HAMMING_ENC_ERR_INJECT_EN
  logic [3:0]        err_pos;

  // Encoder side
  modport slave (
    input  in_valid, in_data, out_ready, err_pos,
    output in_ready, out_valid, out_code, enc_cnt
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready, err_pos,
    input  in_ready, out_valid, out_code, enc_cnt
  );
`else
  // Encoder side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, enc_cnt
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, enc_cnt
  );
`endif
endinterface

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(IP_BIT+4, IP_BIT) encoder. Parity is accumulated one
// data bit per cycle; the codeword is presented on a registered valid/ready
// port in the layout the team's Hamming decoder consumes (position 1 = MSB,
// parity at positions 1, 2, 4, 8).
// Optional macro HAMMING_ENC_ERR_INJECT_EN: adds err_pos, which flips one
// chosen codeword position to exercise the decoder.
module hamming_enc_stream #(
  parameter int unsigned IP_BIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  hamming_enc_stream_if.slave bus
);

  localparam int unsigned CW       = IP_BIT + 4;
  localparam logic [3:0]  LAST_BIT = 4'(IP_BIT - 1);
  localparam logic [CW-1:0] MSB_ONE = {1'b1, {(CW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [IP_BIT-1:0] data_q, data_d;
  logic [IP_BIT-1:0] sh_q, sh_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        acc_q, acc_d;
  logic [CW-1:0]     code_q, code_d;
  logic [7:0]        enc_q, enc_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [3:0]        pos;
  logic [3:0]        acc_fin;
  logic [CW-1:0]     flip_mask;

  // Codeword position of the data bit processed at counter value cnt_q
  always_comb begin
    if (cnt_q == 4'd0) begin
      pos = 4'd3;
    end else if (cnt_q < 4'd4) begin
      pos = cnt_q + 4'd4;
    end else begin
      pos = cnt_q + 4'd5;
    end
  end

  assign acc_fin = acc_q ^ (sh_q[IP_BIT-1] ? pos : 4'd0);

`ifdef HAMMING_ENC_ERR_INJECT_EN
  localparam logic [4:0] CW5 = 5'(CW);
  logic [3:0] err_q, err_d;

  // Single-bit corruption mask; out-of-range positions leave the code clean
  always_comb begin
    if ((err_q != 4'd0) && ({1'b0, err_q} <= CW5)) begin
      flip_mask = MSB_ONE >> (err_q - 4'd1);
    end else begin
      flip_mask = '0;
    end
  end
`else
  assign flip_mask = '0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    code_d  = code_q;
    enc_d   = enc_q;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.in_data;
          sh_d    = bus.in_data;
          cnt_d   = 4'd0;
          acc_d   = 4'd0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
          err_d   = bus.err_pos;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_fin;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) begin
          code_d  = {acc_fin[0], acc_fin[1], data_q[IP_BIT-1], acc_fin[2],
                     data_q[IP_BIT-2:IP_BIT-4], acc_fin[3],
                     data_q[IP_BIT-5:0]} ^ flip_mask;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          enc_d   = enc_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      sh_q        <= '0;
      cnt_q       <= 4'd0;
      acc_q       <= 4'd0;
      code_q      <= '0;
      enc_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
      err_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      code_q      <= code_d;
      enc_q       <= enc_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == HOLD);
`ifdef HAMMING_ENC_ERR_INJECT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = code_q;
  assign bus.enc_cnt   = enc_q;

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Directed bench for hamming_enc_stream (IP_BIT=8) with a codeword
// scoreboard, an independent reference encoder and a reference decoder.
module tb_hamming_enc_stream;

  localparam int P  = 8;
  localparam int CW = P + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   enc_model = 0;
  int   exp_q[$];
  int   dat_q[$];

  hamming_enc_stream_if #(.IP_BIT(P)) bus ();

  hamming_enc_stream #(.IP_BIT(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit is_pow2(input int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 8);
  endfunction

  // Place data MSB-first into non-power-of-two positions, then set parity
  function automatic int ref_encode(input int d, input int e);
    int code = 0;
    int syn  = 0;
    int k    = P - 1;
    for (int p = 1; p <= CW; p++) begin
      if (!is_pow2(p)) begin
        if (((d >> k) & 1) == 1) begin
          code |= 1 << (CW - p);
          syn  ^= p;
        end
        k--;
      end
    end
    if ((syn & 1) != 0) code |= 1 << (CW - 1);
    if ((syn & 2) != 0) code |= 1 << (CW - 2);
    if ((syn & 4) != 0) code |= 1 << (CW - 4);
    if ((syn & 8) != 0) code |= 1 << (CW - 8);
    if (e >= 1 && e <= CW) code ^= 1 << (CW - e);
    return code;
  endfunction

  // Syndrome decode with single-bit correction, returns data
  function automatic int ref_decode(input int c);
    int syn = 0;
    int d   = 0;
    for (int p = 1; p <= CW; p++) begin
      if (((c >> (CW - p)) & 1) == 1) syn ^= p;
    end
    if (syn != 0 && syn <= CW) c ^= 1 << (CW - syn);
    for (int p = 1; p <= CW; p++) begin
      if (!is_pow2(p)) d = (d << 1) | ((c >> (CW - p)) & 1);
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a word until the DUT accepts it; push the expected codeword
  task automatic do_accept(input int d, input int e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
`ifdef HAMMING_ENC_ERR_INJECT_EN
    bus.err_pos  = 4'(e);
`endif
    for (int n = 0; n < 50; n++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("accept", 32'(ok), 32'd1);
    if (ok) begin
      exp_q.push_back(ref_encode(d, e));
      dat_q.push_back(d);
    end
  endtask

  // Edges from accept until out_valid, -1 if the bound expires
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(P));
  endtask

  // Compare the presented codeword against the scoreboard and release it
  task automatic take();
    int exp_c;
    int exp_d;
    logic [CW-1:0] got;
    got = bus.out_code;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", got);
    end else begin
      exp_c = exp_q.pop_front();
      exp_d = dat_q.pop_front();
      check("code", 32'(got), 32'(exp_c));
      check("decode", 32'(ref_decode(int'(got))), 32'(exp_d));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    enc_model = (enc_model + 1) % 256;
    check("enc_cnt", 32'(bus.enc_cnt), 32'(enc_model));
    check("valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic send_recv(input int d, input int e);
    int lat;
    do_accept(d, e);
    wait_valid(lat);
    if (lat > 0) take();
  endtask

  initial begin
    int lat;
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef HAMMING_ENC_ERR_INJECT_EN
    bus.err_pos   = 4'd0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_code", 32'(bus.out_code), 32'h000);
    check("rst_enc_cnt", 32'(bus.enc_cnt), 32'd0);

    // All-zero word
    send_recv(8'h00, 0);

    // Known codewords
    do_accept(8'hA5, 0);
    wait_valid(lat);
    check("code_A5", 32'(bus.out_code), 32'hE45);
    if (lat > 0) take();
    do_accept(8'hFF, 0);
    wait_valid(lat);
    check("code_FF", 32'(bus.out_code), 32'hEEF);
    if (lat > 0) take();

    // Backpressure: hold, stray in_valid ignored, then release
    do_accept(8'hA5, 0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i == 1);
      bus.in_data  = 8'h3C;
      @(posedge clk); #1;
      check("bp_code", 32'(bus.out_code), 32'hE45);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    take();
    check("bp_enc_cnt", 32'(bus.enc_cnt), 32'd4);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("stray_ignored", 32'(seen), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Counter wrap after 256 deliveries
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    enc_model = 0;
    check("rst2_enc_cnt", 32'(bus.enc_cnt), 32'd0);
    for (int w = 0; w < 256; w++) begin
      send_recv(int'($urandom_range(0, 255)), 0);
      if (w == 254) check("enc_cnt_255", 32'(bus.enc_cnt), 32'd255);
    end
    check("enc_cnt_wrap", 32'(bus.enc_cnt), 32'd0);

    // Reset during CALC discards the word
    do_accept(8'hA5, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    dat_q.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("midcalc_no_valid", 32'(seen), 32'd0);
    check("midcalc_enc_cnt", 32'(bus.enc_cnt), 32'd0);
    check("midcalc_code", 32'(bus.out_code), 32'h000);

    // out_ready without out_valid is inert
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("idle_ready_enc_cnt", 32'(bus.enc_cnt), 32'd0);

    // Recovery after reset
    send_recv(8'h5A, 0);
    send_recv(8'h01, 0);

`ifdef HAMMING_ENC_ERR_INJECT_EN
    // Deliberate single-bit errors
    do_accept(8'hA5, 5);
    wait_valid(lat);
    check("inj_code_5", 32'(bus.out_code), 32'hEC5);
    if (lat > 0) take();
    do_accept(8'hA5, 13);
    wait_valid(lat);
    check("inj_code_13", 32'(bus.out_code), 32'hE45);
    if (lat > 0) take();
    send_recv(8'h3C, 12);
    send_recv(8'hC3, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
